// File: rtl/wb_cmd_master.sv
// -----------------------------------------------------------------------------
// wb_cmd_master
//
// Wishbone classic single-cycle initiator. Commands (read/write, address, data,
// byte selects) arrive on a valid/ready port and are buffered in a small FIFO.
// Each command becomes exactly one Wishbone cycle. The read data, or a timeout
// error, comes back on a valid/ready response port. Hardware sequencers and the
// debug bridge use it to reach register peripherals without involving the CPU.
//
// Parameters
//   ADDR_W      Wishbone address width.
//   FIFO_DEPTH  command FIFO entries; power of two, >= 2.
//   TIMEOUT     max cycles waiting for i_wb_ack before aborting; 0 = never.
//
// Ports
//   i_clk, i_rst                 clock (posedge), async active-high reset
//   i_cmd_valid / o_cmd_ready    command handshake (ready = FIFO not full)
//   i_cmd_we/adr/dat/sel         command payload
//   o_rsp_valid / i_rsp_ready    response handshake (valid held until ready)
//   o_rsp_dat, o_rsp_err         read data (0 for writes/errors), timeout flag
//   o_busy                       FIFO non-empty or a transaction in flight
//   o_wb_adr/dat/sel/we          Wishbone request, held between transactions
//   o_wb_cyc, o_wb_stb           Wishbone cycle/strobe (always equal)
//   i_wb_dat, i_wb_ack           Wishbone read data and acknowledge
// -----------------------------------------------------------------------------
module wb_cmd_master #(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // command port
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_we,
  input  logic [ADDR_W-1:0] i_cmd_adr,
  input  logic [31:0]       i_cmd_dat,
  input  logic [3:0]        i_cmd_sel,
  // response port
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_dat,
  output logic              o_rsp_err,
  output logic              o_busy,
  // Wishbone initiator
  output logic [ADDR_W-1:0] o_wb_adr,
  output logic [31:0]       o_wb_dat,
  output logic [3:0]        o_wb_sel,
  output logic              o_wb_we,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  input  logic [31:0]       i_wb_dat,
  input  logic              i_wb_ack
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // The timeout counter only ever needs to reach TIMEOUT-1.
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat;
    logic [3:0]        sel;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             cmd_ready_q;
  logic             push;
  logic             pop;
  cmd_t             cmd_in;
  cmd_t             head;

  // cmd_ready_q is the registered "not full" flag, so a push while full is
  // refused even if the FSM pops in the same cycle.
  assign push   = i_cmd_valid && cmd_ready_q;
  assign pop    = (state == IDLE) && (count != '0);
  assign cmd_in = '{we: i_cmd_we, adr: i_cmd_adr, dat: i_cmd_dat, sel: i_cmd_sel};
  assign head   = fifo_mem[rd_ptr];

  // NOTE: every signal driven from always_comb gets a default on entry so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers, independent of block evaluation order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cmd_ready_q <= 1'b1;
    end else begin
      // Pointers are PTR_W bits wide, so they wrap modulo FIFO_DEPTH for free.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      cmd_ready_q <= (count_next != CNT_FULL);
    end
  end

  // NOTE: the storage array has no reset; entries are only read after being
  // written, and a flush is done by resetting the pointers and count.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_in;
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------------
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);

  // State register. Reset returns to IDLE asynchronously, which drops
  // cyc/stb at once since they decode directly from the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. Ack is tested before the timeout so that an ack on the
  // terminal-count cycle still completes the transfer successfully.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (count != '0)     state_next = BUS;
      BUS:     if (i_wb_ack)        state_next = RESP;
               else if (timeout_hit) state_next = RESP;
      RESP:    if (i_rsp_ready)     state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Moore outputs. Leaving BUS always passes through RESP and IDLE, so cyc is
  // low for at least two cycles between transactions; slaves that generate
  // ack as cyc & !ack therefore always see a fresh cycle.
  always_comb begin
    o_wb_cyc    = (state == BUS);
    o_wb_stb    = (state == BUS);
    o_rsp_valid = (state == RESP);
    o_busy      = (state != IDLE) || (count != '0);
    o_cmd_ready = cmd_ready_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath: Wishbone request, timeout counter, response capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wb_adr  <= '0;
      o_wb_dat  <= '0;
      o_wb_sel  <= '0;
      o_wb_we   <= 1'b0;
      to_cnt    <= '0;
      o_rsp_dat <= '0;
      o_rsp_err <= 1'b0;
    end else begin
      // Request fields change only when a new command is popped, so they are
      // stable throughout BUS and keep their last values while idle.
      if (pop) begin
        o_wb_adr <= head.adr;
        o_wb_dat <= head.dat;
        o_wb_sel <= head.sel;
        o_wb_we  <= head.we;
      end

      if (pop)                to_cnt <= '0;
      else if (state == BUS)  to_cnt <= to_cnt + 1'b1;

      if (state == BUS) begin
        if (i_wb_ack) begin
          o_rsp_dat <= o_wb_we ? 32'h0 : i_wb_dat;
          o_rsp_err <= 1'b0;
        end else if (timeout_hit) begin
          o_rsp_dat <= 32'h0;
          o_rsp_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_wb_cmd_master
//
// Directed bench for wb_cmd_master (ADDR_W=32, FIFO_DEPTH=4, TIMEOUT=8).
// A small Wishbone slave model acks after a programmable number of cycles,
// returns address-derived read data and never acks the "dead" address 0x10.
// -----------------------------------------------------------------------------
module tb_wb_cmd_master;

  localparam logic [31:0] DEAD_ADR = 32'h10;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        busy;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdat;
  logic        slave_ack;

  int n_cmp = 0;
  int n_bad = 0;

  wb_cmd_master #(
    .ADDR_W    (32),
    .FIFO_DEPTH(4),
    .TIMEOUT   (8)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_we   (cmd_we),
    .i_cmd_adr  (cmd_adr),
    .i_cmd_dat  (cmd_dat),
    .i_cmd_sel  (cmd_sel),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_dat  (rsp_dat),
    .o_rsp_err  (rsp_err),
    .o_busy     (busy),
    .o_wb_adr   (wb_adr),
    .o_wb_dat   (wb_dat),
    .o_wb_sel   (wb_sel),
    .o_wb_we    (wb_we),
    .o_wb_cyc   (wb_cyc),
    .o_wb_stb   (wb_stb),
    .i_wb_dat   (wb_rdat),
    .i_wb_ack   (slave_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Slave model: ack goes high wait_n edges after cyc is first seen, for one
  // cycle. wait_n = 0 is a 1-wait slave (ack seen by the master on the second
  // cyc cycle).
  // ---------------------------------------------------------------------------
  int wait_n = 0;
  int slave_cnt;

  always_comb wb_rdat = (wb_adr == 32'h8) ? 32'h0000_0155 : {16'hD000, wb_adr[15:0]};

  always @(posedge clk) begin
    if (rst || !wb_cyc) begin
      slave_cnt <= 0;
      slave_ack <= 1'b0;
    end else if (slave_ack) begin
      slave_ack <= 1'b0;
    end else if (wb_adr != DEAD_ADR && slave_cnt == wait_n) begin
      slave_ack <= 1'b1;
    end else begin
      slave_cnt <= slave_cnt + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: edge counter, cyc pulse length, request stability during cyc.
  // ---------------------------------------------------------------------------
  int          edge_n   = 0;
  int          run      = 0;
  int          last_len = 0;
  logic        stab_bad = 1'b0;
  logic [68:0] snap;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (wb_cyc) begin
      if (run == 0) snap <= {wb_we, wb_adr, wb_dat, wb_sel};
      else if (snap != {wb_we, wb_adr, wb_dat, wb_sel}) stab_bad <= 1'b1;
      run <= run + 1;
    end else if (run != 0) begin
      last_len <= run;
      run      <= 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command and return the edge index at which it was accepted.
  task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output int acc);
    int n;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    n = 0;
    while (!cmd_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("push_ready_timeout", {31'd0, cmd_ready}, 32'd1);
    step();
    acc       = edge_n;
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, check it, consume it; return the edge
  // index at which o_rsp_valid was first seen.
  task automatic wait_rsp(input string tag, input logic [31:0] exp_dat,
                          input logic exp_err, output int seen);
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      step();
      n++;
    end
    seen = edge_n;
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_dat"}, rsp_dat, exp_dat);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int   acc;
    int   acc2;
    int   seen;
    logic seen_activity;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    check("rst_stb", {31'd0, wb_stb}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_wb_adr", wb_adr, 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // 1. Write to a 1-wait slave
    wait_n = 0;
    push(1'b1, 32'h0, 32'h8000_03FF, 4'hF, acc);
    step();
    check("t1_cyc_n1", {31'd0, wb_cyc}, 32'd1);
    check("t1_stb_n1", {31'd0, wb_stb}, 32'd1);
    check("t1_we", {31'd0, wb_we}, 32'd1);
    check("t1_wb_dat", wb_dat, 32'h8000_03FF);
    check("t1_wb_sel", {28'd0, wb_sel}, 32'hF);
    step();
    check("t1_cyc_n2", {31'd0, wb_cyc}, 32'd1);
    check("t1_rsp_early", {31'd0, rsp_valid}, 32'd0);
    wait_rsp("t1_rsp", 32'h0, 1'b0, seen);
    check("t1_latency", seen - acc, 32'd3);
    check("t1_pulse_len", last_len, 32'd2);
    check("t1_busy_done", {31'd0, busy}, 32'd0);

    // 2. Read with stable Wishbone outputs
    push(1'b0, 32'h8, 32'h1234_5678, 4'hF, acc);
    step();
    check("t2_we", {31'd0, wb_we}, 32'd0);
    check("t2_adr", wb_adr, 32'h8);
    wait_rsp("t2_rsp", 32'h0000_0155, 1'b0, seen);
    check("t2_stable", {31'd0, stab_bad}, 32'd0);
    step();
    check("t2_adr_hold_idle", wb_adr, 32'h8);

    // 3. Timeout on a dead address, then the queued read proceeds
    push(1'b1, DEAD_ADR, 32'hCAFE_0001, 4'h1, acc);
    push(1'b0, 32'h14, 32'h0, 4'hF, acc2);
    wait_rsp("t3_timeout", 32'h0, 1'b1, seen);
    check("t3_latency", seen - acc, 32'd9);
    check("t3_pulse_len", last_len, 32'd8);
    wait_rsp("t3_next", 32'hD000_0014, 1'b0, seen);

    // 4. FIFO full with the FSM holding an unconsumed response
    push(1'b1, 32'h1C, 32'hAAAA_5555, 4'h3, acc);
    for (int n = 0; n < 20 && !rsp_valid; n++) step();
    check("t4_pro_valid", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 4; i++) push(1'b0, 32'h20 + 32'(4 * i), 32'h0, 4'hF, acc);
    check("t4_ready_full", {31'd0, cmd_ready}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h30;
    repeat (3) step();
    check("t4_ready_held", {31'd0, cmd_ready}, 32'd0);
    check("t4_pro_dat", rsp_dat, 32'h0);
    check("t4_pro_err", {31'd0, rsp_err}, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t4_pro_drop", {31'd0, rsp_valid}, 32'd0);
    check("t4_ready_after_rsp", {31'd0, cmd_ready}, 32'd0);
    step();
    check("t4_ready_after_pop", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_rsp($sformatf("t4_rsp%0d", i), {16'hD000, 16'h20 + 16'(4 * i)}, 1'b0, seen);
    end
    check("t4_busy_done", {31'd0, busy}, 32'd0);

    // 5. Ack on the timeout terminal-count cycle: ack wins
    wait_n = 6;
    push(1'b0, 32'h40, 32'h0, 4'hF, acc);
    wait_rsp("t5_rsp", 32'hD000_0040, 1'b0, seen);
    check("t5_latency", seen - acc, 32'd9);
    check("t5_pulse_len", last_len, 32'd8);
    check("t5_stable", {31'd0, stab_bad}, 32'd0);
    wait_n = 0;

    // 6. Reset mid-transaction with two commands queued
    push(1'b1, DEAD_ADR, 32'h0, 4'hF, acc);
    push(1'b0, 32'h20, 32'h0, 4'hF, acc);
    push(1'b0, 32'h24, 32'h0, 4'hF, acc);
    check("t6_cyc_before", {31'd0, wb_cyc}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_cyc_async", {31'd0, wb_cyc}, 32'd0);
    check("t6_stb_async", {31'd0, wb_stb}, 32'd0);
    check("t6_busy_async", {31'd0, busy}, 32'd0);
    repeat (2) step();
    rst = 1'b0;
    step();
    check("t6_ready", {31'd0, cmd_ready}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd0);
    seen_activity = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (wb_cyc || rsp_valid) seen_activity = 1'b1;
    end
    check("t6_no_activity", {31'd0, seen_activity}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
